// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end.
//   - fstate_t : fetch sequencer states (FS_IDLE, FS_REQ, FS_DONE)
//   - PCSRC_*  : next-PC source selector codes driven by the control unit
//   - RESET_PC_DFLT : default PC after reset
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_DONE = 2'b10
    } fstate_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0040_0000;

endpackage

// File: rtl/npc_calc.sv
// Next-PC candidate generation (purely combinational).
// Ports:
//   pc        in  32  current PC
//   ir_field  in  26  low 26 bits of the instruction register; the branch
//                     offset lives in [15:0] and the jump index in [25:0]
//   jr_target in  32  register-sourced target for JR/JALR
//   pc_src    in  2   selector (PCSRC_* codes)
//   pc_plus4  out 32  pc + 4, wrapping at 2^32
//   npc       out 32  selected next PC
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] ir_field,
    input  logic [31:0] jr_target,
    input  logic [1:0]  pc_src,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc
);

    logic [31:0] seq_s;
    logic [31:0] br_s;
    logic [31:0] jmp_s;

    // Candidate adders; the branch offset is a sign-extended word offset.
    always_comb begin
        seq_s = pc + 32'd4;
        br_s  = seq_s + {{14{ir_field[15]}}, ir_field[15:0], 2'b00};
        jmp_s = {seq_s[31:28], ir_field, 2'b00};
    end

    // Source select. JR targets pass through unchecked; alignment is
    // enforced when the fetch is started.
    always_comb begin
        npc = seq_s;
        case (pc_src)
            PCSRC_SEQ: npc = seq_s;
            PCSRC_BR:  npc = br_s;
            PCSRC_J:   npc = jmp_s;
            PCSRC_JR:  npc = jr_target;
            default:   npc = seq_s;
        endcase
    end

    assign pc_plus4 = seq_s;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns PC and IR, runs the req/ack fetch
// handshake with instruction memory and applies control-unit PC updates.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_start              request a fetch at the current (or just-written) PC
//   fetch_done / fetch_err   one-cycle completion / error pulses
//   busy                     high in REQ and DONE
//   pc_wr, pc_src, jr_target PC update controls (honoured only in IDLE)
//   pc_out, pc_plus4, ir_out architectural PC, PC+4 and instruction register
//   imem_req, imem_addr      memory request and address (= pc_out)
//   imem_ack, imem_rdata     memory acknowledge and read data (same cycle)
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DFLT,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        busy,
    input  logic        pc_wr,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);
    import cpu_pkg::*;

    // Last REQ cycle index before giving up on the memory.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    fstate_t     state_r;
    logic [7:0]  cnt_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        fetch_done_r;
    logic        fetch_err_r;
    logic        busy_r;
    logic        imem_req_r;

    logic [31:0] npc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] fetch_pc_s;

    npc_calc u_npc (
        .pc        (pc_r),
        .ir_field  (ir_r[25:0]),
        .jr_target (jr_target),
        .pc_src    (pc_src),
        .pc_plus4  (pc_plus4_s),
        .npc       (npc_s)
    );

    // PC that a fetch started this cycle will use: a simultaneous pc_wr
    // takes effect before the fetch, so its alignment is what matters.
    always_comb begin
        if (pc_wr) begin
            fetch_pc_s = npc_s;
        end else begin
            fetch_pc_s = pc_r;
        end
    end

    // Fetch FSM, wait counter, PC/IR and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FS_IDLE;
            cnt_r        <= 8'd0;
            pc_r         <= RESET_PC;
            ir_r         <= 32'd0;
            fetch_done_r <= 1'b0;
            fetch_err_r  <= 1'b0;
            busy_r       <= 1'b0;
            imem_req_r   <= 1'b0;
        end else begin
            fetch_done_r <= 1'b0;
            fetch_err_r  <= 1'b0;
            case (state_r)
                FS_IDLE: begin
                    if (pc_wr) begin
                        pc_r <= npc_s;
                    end
                    if (fetch_start) begin
                        if (fetch_pc_s[1:0] != 2'b00) begin
                            fetch_err_r <= 1'b1;
                        end else begin
                            state_r    <= FS_REQ;
                            cnt_r      <= 8'd0;
                            imem_req_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                FS_REQ: begin
                    // An ack on the final allowed cycle still completes.
                    if (imem_ack) begin
                        ir_r         <= imem_rdata;
                        state_r      <= FS_DONE;
                        imem_req_r   <= 1'b0;
                        fetch_done_r <= 1'b1;
                    end else if (cnt_r == TMO_LAST) begin
                        state_r     <= FS_IDLE;
                        imem_req_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        fetch_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                FS_DONE: begin
                    state_r <= FS_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= FS_IDLE;
                    imem_req_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_done = fetch_done_r;
    assign fetch_err  = fetch_err_r;
    assign busy       = busy_r;
    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign pc_out     = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign ir_out     = ir_r;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl with a behavioural PC/IR model.
module tb_ifetch_ctrl;

    localparam int          TMO  = 16;
    localparam logic [31:0] RPC  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic [31:0] jr_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] ir_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] pc_m;
    logic [31:0] ir_m;

    ifetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .busy       (busy),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .jr_target  (jr_target),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .ir_out     (ir_out),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_npc(input logic [1:0] src, input logic [31:0] jr);
        logic [31:0] p4;
        int          off;
        p4 = pc_m + 32'd4;
        case (src)
            2'b00: return p4;
            2'b01: begin
                off = int'($signed(ir_m[15:0]));
                return p4 + 32'(off * 4);
            end
            2'b10: return (p4 & 32'hF000_0000) | ((ir_m & 32'h03FF_FFFF) << 2);
            default: return jr;
        endcase
    endfunction

    // Idle-state PC update, then compare PC and PC+4 with the model.
    task automatic do_pcwr(input logic [1:0] src, input logic [31:0] jr);
        logic [31:0] exp_pc;
        exp_pc    = model_npc(src, jr);
        pc_wr     = 1'b1;
        pc_src    = src;
        jr_target = jr;
        tick();
        pc_wr = 1'b0;
        pc_m  = exp_pc;
        checks++;
        if (pc_out !== pc_m) begin
            failures++;
            $display("FAIL pcwr_pc: got %h expected %h (src %b)", pc_out, pc_m, src);
        end
        checks++;
        if (pc_plus4 !== pc_m + 32'd4) begin
            failures++;
            $display("FAIL pcwr_plus4: got %h expected %h", pc_plus4, pc_m + 32'd4);
        end
    endtask

    // One fetch from IDLE; ack arrives after 'delay' wait cycles (timeout if
    // delay >= TMO). Optionally combined with a pc_wr in the start cycle.
    // Stray fetch_start / pc_wr pulses during REQ must be ignored.
    task automatic do_fetch(input int delay, input logic [31:0] word,
                            input bit wr, input logic [1:0] src, input logic [31:0] jr);
        logic [31:0] exp_pc;
        int          n_req;
        exp_pc      = wr ? model_npc(src, jr) : pc_m;
        fetch_start = 1'b1;
        pc_wr       = wr;
        pc_src      = src;
        jr_target   = jr;
        tick();
        fetch_start = 1'b0;
        pc_wr       = 1'b0;
        pc_m        = exp_pc;
        checks++;
        if (pc_out !== pc_m) begin
            failures++;
            $display("FAIL fetch_pc: got %h expected %h", pc_out, pc_m);
        end
        if (pc_m[1:0] != 2'b00) begin
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL misalign: err=%b req=%b busy=%b expected 1,0,0", fetch_err, imem_req, busy);
            end
            tick();
            checks++;
            if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL misalign_pulse: err=%b req=%b expected 0,0", fetch_err, imem_req);
            end
            return;
        end
        n_req = (delay < TMO) ? delay + 1 : TMO;
        for (int i = 0; i < n_req; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc_m || busy !== 1'b1 ||
                fetch_done !== 1'b0 || fetch_err !== 1'b0) begin
                failures++;
                $display("FAIL req_cycle%0d: req=%b addr=%h busy=%b done=%b err=%b expected 1,%h,1,0,0",
                         i, imem_req, imem_addr, busy, fetch_done, fetch_err, pc_m);
            end
            if (i == delay) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
            end else begin
                imem_ack    = 1'b0;
                imem_rdata  = $urandom;
                fetch_start = 1'($urandom_range(0, 1));
                pc_wr       = 1'($urandom_range(0, 1));
                pc_src      = 2'($urandom_range(0, 3));
                jr_target   = $urandom;
            end
            tick();
            imem_ack    = 1'b0;
            fetch_start = 1'b0;
            pc_wr       = 1'b0;
        end
        if (delay < TMO) begin
            ir_m = word;
            checks++;
            if (fetch_done !== 1'b1 || ir_out !== ir_m || imem_req !== 1'b0 ||
                busy !== 1'b1 || pc_out !== pc_m) begin
                failures++;
                $display("FAIL done: done=%b ir=%h req=%b busy=%b pc=%h expected 1,%h,0,1,%h",
                         fetch_done, ir_out, imem_req, busy, pc_out, ir_m, pc_m);
            end
            tick();
            checks++;
            if (fetch_done !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse: done=%b busy=%b req=%b expected 0,0,0", fetch_done, busy, imem_req);
            end
        end else begin
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0 ||
                ir_out !== ir_m || fetch_done !== 1'b0) begin
                failures++;
                $display("FAIL timeout: err=%b req=%b busy=%b ir=%h done=%b expected 1,0,0,%h,0",
                         fetch_err, imem_req, busy, ir_out, fetch_done, ir_m);
            end
            tick();
            checks++;
            if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL timeout_pulse: err=%b req=%b expected 0,0", fetch_err, imem_req);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        pc_m = RPC;
        ir_m = 32'd0;
        checks++;
        if (pc_out !== RPC || pc_plus4 !== RPC + 32'd4 || ir_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: pc=%h p4=%h ir=%h expected %h,%h,0", pc_out, pc_plus4, ir_out, RPC, RPC + 32'd4);
        end
        checks++;
        if (imem_req !== 1'b0 || fetch_done !== 1'b0 || fetch_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: req=%b done=%b err=%b busy=%b expected 0", imem_req, fetch_done, fetch_err, busy);
        end
    endtask

    task automatic test_basic_fetch();
        do_fetch(0, 32'h2008_0005, 1'b0, 2'b00, 32'd0);
        checks++;
        if (ir_out !== 32'h2008_0005) begin
            failures++;
            $display("FAIL basic_ir: got %h expected 20080005", ir_out);
        end
    endtask

    task automatic test_delayed_ack();
        do_fetch(5, $urandom, 1'b0, 2'b00, 32'd0);
        do_fetch(TMO - 1, $urandom, 1'b0, 2'b00, 32'd0);
    endtask

    task automatic test_timeout();
        do_fetch(TMO + 4, $urandom, 1'b0, 2'b00, 32'd0);
    endtask

    task automatic test_branch_jump();
        do_pcwr(2'b11, 32'h0040_0010);
        do_fetch(0, 32'h1000_FFFF, 1'b0, 2'b00, 32'd0);
        do_pcwr(2'b01, 32'd0);
        checks++;
        if (pc_out !== 32'h0040_0010) begin
            failures++;
            $display("FAIL branch_target: got %h expected 00400010", pc_out);
        end
        do_fetch(1, 32'h0810_0000, 1'b0, 2'b00, 32'd0);
        do_pcwr(2'b10, 32'd0);
        checks++;
        if (pc_out !== 32'h0040_0000) begin
            failures++;
            $display("FAIL jump_target: got %h expected 00400000", pc_out);
        end
    endtask

    task automatic test_jr_misalign();
        do_pcwr(2'b11, 32'h0040_0006);
        do_fetch(0, $urandom, 1'b0, 2'b00, 32'd0);
        // write + start together: fetch uses the new, aligned PC
        do_fetch(2, $urandom, 1'b1, 2'b11, 32'h0040_0100);
    endtask

    task automatic test_wrap();
        do_pcwr(2'b11, 32'hFFFF_FFFC);
        checks++;
        if (pc_plus4 !== 32'd0) begin
            failures++;
            $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4);
        end
        do_pcwr(2'b00, 32'd0);
        checks++;
        if (pc_out !== 32'd0) begin
            failures++;
            $display("FAIL wrap_seq: got %h expected 00000000", pc_out);
        end
    endtask

    task automatic test_random();
        logic [31:0] jr;
        for (int n = 0; n < 60; n++) begin
            jr = $urandom;
            if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
            case ($urandom_range(0, 3))
                0: do_pcwr(2'($urandom_range(0, 3)), jr);
                1: do_fetch($urandom_range(0, 20), $urandom, 1'b1, 2'($urandom_range(0, 3)), jr);
                2: do_fetch($urandom_range(0, 6), $urandom, 1'b0, 2'b00, 32'd0);
                default: begin
                    // stray ack while idle must not touch IR or PC
                    imem_ack   = 1'b1;
                    imem_rdata = $urandom;
                    tick();
                    imem_ack = 1'b0;
                    checks++;
                    if (ir_out !== ir_m || pc_out !== pc_m || fetch_done !== 1'b0) begin
                        failures++;
                        $display("FAIL stray_ack: ir=%h pc=%h done=%b expected %h,%h,0", ir_out, pc_out, fetch_done, ir_m, pc_m);
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_in_req();
        do_pcwr(2'b11, 32'h0040_0020);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        pc_m = RPC;
        ir_m = 32'd0;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== RPC || ir_out !== 32'd0 || fetch_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_req: req=%b pc=%h ir=%h done=%b expected 0,%h,0,0", imem_req, pc_out, ir_out, fetch_done, RPC);
        end
        tick();
        imem_ack = 1'b0;
        checks++;
        if (fetch_done !== 1'b0 || ir_out !== 32'd0 || busy !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: done=%b ir=%h busy=%b req=%b expected 0,0,0,0", fetch_done, ir_out, busy, imem_req);
        end
    endtask

    initial begin
        rst         = 1'b1;
        fetch_start = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = 2'b00;
        jr_target   = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        pc_m        = RPC;
        ir_m        = 32'd0;
        test_reset();
        test_basic_fetch();
        test_delayed_ack();
        test_timeout();
        test_branch_jump();
        test_jr_misalign();
        test_wrap();
        test_random();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
